// File: rtl/sync_down_counter_if.sv
// Handshake bundle for sync_down_counter: control/load inputs and count/status outputs.
interface sync_down_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             mode;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             running;
  logic             done;

  modport master (
    output enable, load, load_value, mode,
    input  count, tc, running, done
  );

  modport slave (
    input  enable, load, load_value, mode,
    output count, tc, running, done
  );
endinterface

// File: rtl/sync_down_counter.sv
// Loadable down counter with one-cycle terminal-count pulse, one-shot or auto-reload.
// Optional enabled-cycle prescaler is built only when DOWN_COUNTER_PRESCALE_EN is defined.
module sync_down_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PRESCALE = 4
) (
  input logic                clk,
  input logic                rst,
  sync_down_counter_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       r_state, w_state_d;
  logic [WIDTH-1:0] r_count, w_count_d;
  logic [WIDTH-1:0] r_reload, w_reload_d;
  logic             r_mode, w_mode_d;
  logic             r_tc, w_tc_d;
  logic             w_tick;

`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PreLast = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre, w_pre_d;

  // Prescaler only advances on enabled RUN cycles; a tick fires as it wraps.
  always_comb begin
    w_pre_d = r_pre;
    if (bus.load) begin
      w_pre_d = '0;
    end else if (r_state == StRun && bus.enable) begin
      w_pre_d = (r_pre == PreLast) ? '0 : r_pre + PW'(1);
    end
  end

  assign w_tick = bus.enable && (r_pre == PreLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else begin
      r_pre <= w_pre_d;
    end
  end
`else
  logic w_unused_prescale;
  assign w_unused_prescale = ^PRESCALE;
  assign w_tick            = bus.enable;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_count_d  = r_count;
    w_reload_d = r_reload;
    w_mode_d   = r_mode;
    w_tc_d     = 1'b0;
    if (bus.load) begin
      w_count_d  = bus.load_value;
      w_reload_d = bus.load_value;
      w_mode_d   = bus.mode;
      w_state_d  = (bus.load_value != '0) ? StRun : StDone;
    end else if (r_state == StRun && w_tick) begin
      if (r_count > WIDTH'(1)) begin
        w_count_d = r_count - WIDTH'(1);
      end else begin
        w_tc_d = 1'b1;
        if (r_mode) begin
          w_count_d = r_reload;
        end else begin
          w_count_d = '0;
          w_state_d = StDone;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_count  <= w_count_d;
      r_reload <= w_reload_d;
      r_mode   <= w_mode_d;
      r_tc     <= w_tc_d;
    end
  end

  assign bus.count   = r_count;
  assign bus.tc      = r_tc;
  assign bus.running = (r_state == StRun);
  assign bus.done    = (r_state == StDone);

endmodule

// File: tb/tb_sync_down_counter.sv
// Scoreboard bench for sync_down_counter: stimulus pushes expected outputs, a monitor checks them.
module tb_sync_down_counter;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned PRESCALE = 4;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             running;
    logic             done;
    string            name;
  } exp_t;

  logic clk;
  logic rst;
  logic strobe;
  exp_t sb_q[$];
  int   n_vec;
  int   n_fail;

  sync_down_counter_if #(.WIDTH(WIDTH)) bus ();

  sync_down_counter #(
    .WIDTH   (WIDTH),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // Monitor: outputs are valid every cycle, and right after an async reset strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge strobe);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        if (bus.count !== e.count || bus.tc !== e.tc || bus.running !== e.running ||
            bus.done !== e.done) begin
          n_fail++;
          $display("FAIL %s: got count=%0d tc=%b run=%b done=%b, want count=%0d tc=%b run=%b done=%b",
                   e.name, bus.count, bus.tc, bus.running, bus.done,
                   e.count, e.tc, e.running, e.done);
        end
      end
    end
  end

  task automatic push(input logic [WIDTH-1:0] c, input logic t, input logic r, input logic d,
                      input string name);
    exp_t e;
    e.count = c; e.tc = t; e.running = r; e.done = d; e.name = name;
    sb_q.push_back(e);
  endtask

  // One clock of stimulus; expected values describe outputs after the next rising edge.
  task automatic step(input logic en, input logic ld, input logic [WIDTH-1:0] lv, input logic md,
                      input logic [WIDTH-1:0] c, input logic t, input logic r, input logic d,
                      input string name);
    @(negedge clk);
    bus.enable     = en;
    bus.load       = ld;
    bus.load_value = lv;
    bus.mode       = md;
    push(c, t, r, d, name);
  endtask

  task automatic async_reset_check(input string name);
    @(negedge clk);
    #2;
    rst = 1'b1;
    push('0, 1'b0, 1'b0, 1'b0, name);
    strobe = 1'b1;
    #1;
    strobe = 1'b0;
  endtask

  initial begin
    n_vec          = 0;
    n_fail         = 0;
    strobe         = 1'b0;
    rst            = 1'b1;
    bus.enable     = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.mode       = 1'b0;
    #12;
    rst = 1'b0;
    #1;
    push('0, 1'b0, 1'b0, 1'b0, "reset_release");
    strobe = 1'b1;
    #1;
    strobe = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0, 0, "idle_enable_0");
    step(1, 0, 0, 0, 0, 0, 0, 0, "idle_enable_1");

`ifdef DOWN_COUNTER_PRESCALE_EN
    // V=2 one-shot with divide-by-4: count drops every 4 enabled cycles, tc on the 8th.
    step(1, 1, 2, 0, 2, 0, 1, 0, "pre_load");
    for (int i = 1; i <= 8; i++) begin
      if (i < 4)       step(1, 0, 0, 0, 2, 0, 1, 0, "pre_cnt2");
      else if (i < 8)  step(1, 0, 0, 0, 1, 0, 1, 0, "pre_cnt1");
      else             step(1, 0, 0, 0, 0, 1, 0, 1, "pre_expire");
    end
    step(1, 0, 0, 0, 0, 0, 0, 1, "pre_done_hold");

    step(1, 1, 2, 0, 2, 0, 1, 0, "pre_rst_load");
    step(1, 0, 0, 0, 2, 0, 1, 0, "pre_rst_c1");
    step(1, 0, 0, 0, 2, 0, 1, 0, "pre_rst_c2");
    step(1, 0, 0, 0, 2, 0, 1, 0, "pre_rst_c3");
    step(1, 0, 0, 0, 1, 0, 1, 0, "pre_rst_c4");
    async_reset_check("pre_rst_async");
    step(1, 0, 0, 0, 0, 0, 0, 0, "pre_rst_held");
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 0, "pre_after_rst_idle");
`else
    // One-shot V=5.
    step(1, 1, 5, 0, 5, 0, 1, 0, "os_load");
    step(1, 0, 0, 0, 4, 0, 1, 0, "os_4");
    step(1, 0, 0, 0, 3, 0, 1, 0, "os_3");
    step(1, 0, 0, 0, 2, 0, 1, 0, "os_2");
    step(1, 0, 0, 0, 1, 0, 1, 0, "os_1");
    step(1, 0, 0, 0, 0, 1, 0, 1, "os_expire");
    step(1, 0, 0, 0, 0, 0, 0, 1, "os_done_hold0");
    step(1, 0, 0, 0, 0, 0, 0, 1, "os_done_hold1");

    // Auto-reload V=3 for 12 ticks: 2,1,3(tc) repeating, four pulses.
    step(1, 1, 3, 1, 3, 0, 1, 0, "ar_load");
    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0:       step(1, 0, 0, 0, 2, 0, 1, 0, "ar_2");
        1:       step(1, 0, 0, 0, 1, 0, 1, 0, "ar_1");
        default: step(1, 0, 0, 0, 3, 1, 1, 0, "ar_reload");
      endcase
    end

    // Hold with enable low.
    step(1, 1, 9, 0, 9, 0, 1, 0, "hold_load");
    step(1, 0, 0, 0, 8, 0, 1, 0, "hold_8");
    step(1, 0, 0, 0, 7, 0, 1, 0, "hold_7");
    step(1, 0, 0, 0, 6, 0, 1, 0, "hold_6");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 6, 0, 1, 0, "hold_frozen");
    step(1, 0, 0, 0, 5, 0, 1, 0, "hold_resume");

    // Zero load goes straight to DONE without tc.
    step(1, 1, 0, 0, 0, 0, 0, 1, "zero_load");
    step(1, 0, 0, 0, 0, 0, 0, 1, "zero_hold");
    step(1, 1, 1, 0, 1, 0, 1, 0, "v1_load");
    step(1, 0, 0, 0, 0, 1, 0, 1, "v1_expire");

    // Load coinciding with expiry wins: no tc.
    step(1, 1, 1, 1, 1, 0, 1, 0, "race_arm");
    step(1, 1, 2, 0, 2, 0, 1, 0, "race_load_wins");
    step(1, 0, 0, 0, 1, 0, 1, 0, "race_1");
    step(1, 0, 0, 0, 0, 1, 0, 1, "race_expire");

    // Auto-reload of 1: tc on every tick.
    step(1, 1, 1, 1, 1, 0, 1, 0, "ar1_load");
    step(1, 0, 0, 0, 1, 1, 1, 0, "ar1_tc0");
    step(1, 0, 0, 0, 1, 1, 1, 0, "ar1_tc1");
    step(0, 0, 0, 0, 1, 0, 1, 0, "ar1_paused");

    // Asynchronous reset mid-count.
    step(1, 1, 9, 0, 9, 0, 1, 0, "rst_load");
    step(1, 0, 0, 0, 8, 0, 1, 0, "rst_8");
    step(1, 0, 0, 0, 7, 0, 1, 0, "rst_7");
    step(1, 0, 0, 0, 6, 0, 1, 0, "rst_6");
    step(1, 0, 0, 0, 5, 0, 1, 0, "rst_5");
    async_reset_check("rst_async");
    step(1, 0, 0, 0, 0, 0, 0, 0, "rst_held");
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 0, "after_rst_idle");
`endif

    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
